// File: rtl/j1_io_uart.sv
// J1 I/O-bus UART: 4-register window (TXDATA, RXDATA, STATUS, DIVISOR), TX FIFO + 8N1 serializer.
// The receive path is built only when J1_UART_RX_EN is defined.
module j1_io_uart #(
  parameter logic [15:0] BASE         = 16'h1000,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          TX_DEPTH     = 16
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_wdata,
  output logic [15:0] io_din,
  input  logic        uart_rx,
  output logic        uart_tx
);
  localparam int AW = $clog2(TX_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

  logic hit, wr_tx, wr_div, rd_rx, rd_st;
  assign hit    = (io_addr[15:2] == BASE[15:2]);
  assign wr_tx  = io_wr && hit && (io_addr[1:0] == 2'd0);
  assign wr_div = io_wr && hit && (io_addr[1:0] == 2'd3);
  assign rd_rx  = io_rd && hit && (io_addr[1:0] == 2'd1);
  assign rd_st  = io_rd && hit && (io_addr[1:0] == 2'd2);

  logic [15:0] divisor_q, divisor_d;
  logic        tx_ovf_q, tx_ovf_d;

  logic [7:0]  fifo_mem [TX_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        tx_full, tx_empty, tx_pop, push_ok;
  logic [7:0]  fifo_rd_data;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign tx_empty     = (wr_ptr_q == rd_ptr_q);
  assign tx_full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok      = wr_tx && (!tx_full || tx_pop);
  assign fifo_rd_data = fifo_mem[rd_ptr_q[AW-1:0]];

  uart_state_t tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    if (tx_state_q != ST_IDLE) tx_cnt_d = tx_cnt_q - 16'd1;
    case (tx_state_q)
      ST_IDLE: ;
      ST_START:
        if (tx_cnt_q == 16'd0) begin
          tx_state_d = ST_DATA;
          tx_cnt_d   = tx_div_q - 16'd1;
          tx_bit_d   = 3'd0;
        end
      ST_DATA:
        if (tx_cnt_q == 16'd0) begin
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_cnt_d   = tx_div_q - 16'd1;
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = ST_STOP;
        end
      ST_STOP:
        if (tx_cnt_q == 16'd0) tx_state_d = ST_IDLE;
      default: tx_state_d = ST_IDLE;
    endcase
    // Frame start from IDLE or straight out of STOP; the divisor is latched here.
    if ((tx_state_q == ST_IDLE || (tx_state_q == ST_STOP && tx_cnt_q == 16'd0)) && !tx_empty) begin
      tx_pop     = 1'b1;
      tx_state_d = ST_START;
      tx_div_d   = divisor_q;
      tx_cnt_d   = divisor_q - 16'd1;
      tx_shift_d = fifo_rd_data;
    end
  end

  assign uart_tx = (tx_state_q == ST_START) ? 1'b0 :
                   (tx_state_q == ST_DATA)  ? tx_shift_q[0] : 1'b1;

  always_comb begin
    wr_ptr_d  = push_ok ? wr_ptr_q + {{AW{1'b0}}, 1'b1} : wr_ptr_q;
    rd_ptr_d  = tx_pop  ? rd_ptr_q + {{AW{1'b0}}, 1'b1} : rd_ptr_q;
    divisor_d = divisor_q;
    if (wr_div) divisor_d = (io_wdata < 16'd4) ? 16'd4 : io_wdata;
    tx_ovf_d  = (tx_ovf_q && !rd_st) || (wr_tx && !push_ok);
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q[AW-1:0]] <= io_wdata[7:0];
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= 16'd0;
      tx_div_q   <= 16'd0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      divisor_q  <= 16'(CLKS_PER_BIT);
      tx_ovf_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      divisor_q  <= divisor_d;
      tx_ovf_q   <= tx_ovf_d;
    end
  end

  logic [7:0] rx_byte;
  logic       rx_valid, ferr, overrun;

`ifdef J1_UART_RX_EN
  uart_state_t rx_state_q, rx_state_d;
  logic [1:0]  rx_sync_q, rx_sync_d;
  logic        rx_prev_q, rx_prev_d, rx_s;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d, rx_byte_q, rx_byte_d;
  logic        rx_valid_q, rx_valid_d, ferr_q, ferr_d, overrun_q, overrun_d;

  assign rx_s = rx_sync_q[1];

  always_comb begin
    rx_sync_d  = {rx_sync_q[0], uart_rx};
    rx_prev_d  = rx_s;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = rx_valid_q && !rd_rx;
    ferr_d     = ferr_q && !rd_st;
    overrun_d  = overrun_q && !rd_st;
    if (rx_state_q != ST_IDLE) rx_cnt_d = rx_cnt_q - 16'd1;
    case (rx_state_q)
      ST_IDLE:
        if (rx_prev_q && !rx_s) begin
          rx_state_d = ST_START;
          rx_div_d   = divisor_q;
          rx_cnt_d   = (divisor_q >> 1) - 16'd1;
        end
      ST_START:
        if (rx_cnt_q == 16'd0) begin
          rx_state_d = rx_s ? ST_IDLE : ST_DATA;
          rx_cnt_d   = rx_div_q - 16'd1;
          rx_bit_d   = 3'd0;
        end
      ST_DATA:
        if (rx_cnt_q == 16'd0) begin
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          rx_cnt_d   = rx_div_q - 16'd1;
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
        end
      ST_STOP:
        if (rx_cnt_q == 16'd0) begin
          rx_state_d = ST_IDLE;
          if (!rx_s) ferr_d = 1'b1;
          // A read in the completion cycle frees the holder, so the new byte wins.
          if (rx_valid_q && !rd_rx) begin
            overrun_d = 1'b1;
          end else begin
            rx_byte_d  = rx_shift_q;
            rx_valid_d = 1'b1;
          end
        end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_sync_q  <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= 16'd0;
      rx_div_q   <= 16'd0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'd0;
      rx_byte_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      ferr_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rx_sync_q  <= rx_sync_d;
      rx_prev_q  <= rx_prev_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      ferr_q     <= ferr_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rx_byte  = rx_byte_q;
  assign rx_valid = rx_valid_q;
  assign ferr     = ferr_q;
  assign overrun  = overrun_q;
`else
  logic unused_rx;
  assign unused_rx = uart_rx;
  assign rx_byte   = 8'd0;
  assign rx_valid  = 1'b0;
  assign ferr      = 1'b0;
  assign overrun   = 1'b0;
`endif

  always_comb begin
    io_din = 16'd0;
    if (io_rd && hit) begin
      case (io_addr[1:0])
        2'd1:    io_din = {8'h00, rx_byte};
        2'd2:    io_din = {10'b0, tx_ovf_q, ferr, overrun, rx_valid, tx_empty, tx_full};
        2'd3:    io_din = divisor_q;
        default: io_din = 16'd0;
      endcase
    end
  end
endmodule
